// File: rtl/trace_pkg.sv
// Shared types for the write-back trace monitor.
//  trace_entry_t : one captured retire event {seq, pc, rd, data}
//  halt_state_t  : two-state halt FSM encoding
//  sat_add16     : saturating 16-bit add used by the drop counter
package trace_pkg;
  localparam int TRACE_SEQ_W = 16;
  // Entry data/PC width; the monitor's XLEN parameter must match this.
  localparam int TRACE_XLEN  = 32;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [TRACE_XLEN-1:0]  pc;
    logic [4:0]             rd;
    logic [TRACE_XLEN-1:0]  data;
  } trace_entry_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} halt_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// Trace FIFO: DEPTH entries, up to NCH in-order pushes and one pop per cycle.
//  clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//  push         : per-lane push strobes; caller guarantees popcount <= free
//  push_entry   : per-lane entries, written in lane order
//  pop          : remove head (ignored when empty)
//  head_valid   : FIFO non-empty
//  head         : entry at read pointer (from registered storage)
//  count        : current occupancy
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int NCH   = 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             push,
  input  trace_entry_t [NCH-1:0]     push_entry,
  input  logic                       pop,
  output logic                       head_valid,
  output trace_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW-1:0] widx [NCH];
  logic [AW:0]   npush;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rptr];
  assign do_pop     = pop && head_valid;

  // Pushing lanes are packed into consecutive slots starting at wptr.
  always_comb begin
    npush = '0;
    for (int i = 0; i < NCH; i++) begin
      widx[i] = wptr + npush[AW-1:0];
      if (push[i]) npush = npush + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (push[i]) mem[widx[i]] <= push_entry[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + npush[AW-1:0];
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + npush - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/wb_trace_monitor.sv
// Write-back retire trace monitor.
//  clk, rst      : clock, synchronous active-high reset
//  enable        : capture enable (0 freezes capture, counters, watchdog)
//  wb_valid/rd/data/pc : NCH retire channels, ch0 oldest
//  trc_valid/ready/entry : trace drain port (FIFO head)
//  retire_cnt    : retires accepted (wraps)
//  drop_cnt      : events lost to a full FIFO (saturating)
//  overflow, timeout, halted : sticky status flags
module wb_trace_monitor
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NCH         = 1,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 500,
  parameter int HALT_REPEAT = 4,
  parameter int FILTER_X0   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NCH-1:0]            wb_valid,
  input  logic [NCH-1:0][4:0]       wb_rd,
  input  logic [NCH-1:0][XLEN-1:0]  wb_data,
  input  logic [NCH-1:0][XLEN-1:0]  wb_pc,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output trace_entry_t              trc_entry,
  output logic [31:0]               retire_cnt,
  output logic [15:0]               drop_cnt,
  output logic                      overflow,
  output logic                      timeout,
  output logic                      halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(HALT_REPEAT + 1);

  halt_state_t            state;
  logic                   capture, any_ret;
  logic [NCH-1:0]         enq;
  trace_entry_t [NCH-1:0] ent;
  logic [AW:0]            fcount, free, n_enq;
  logic [15:0]            n_ret, n_drop, seq;
  logic [XLEN-1:0]        hi_pc, last_pc;
  logic [RW-1:0]          rep_cnt, rep_nxt;
  logic [31:0]            idle_cnt;

  // Free slots come from the occupancy before this cycle's pop, so a
  // same-cycle drain never makes room for a same-cycle push.
  always_comb begin
    capture = enable && (state == ST_RUN);
    free    = (AW+1)'(DEPTH) - fcount;
    n_ret   = '0;
    n_drop  = '0;
    n_enq   = '0;
    enq     = '0;
    ent     = '0;
    any_ret = 1'b0;
    hi_pc   = last_pc;
    for (int i = 0; i < NCH; i++) begin
      ent[i].seq  = seq + n_ret;
      ent[i].pc   = wb_pc[i];
      ent[i].rd   = wb_rd[i];
      ent[i].data = wb_data[i];
      if (capture && wb_valid[i]) begin
        n_ret   = n_ret + 16'd1;
        any_ret = 1'b1;
        hi_pc   = wb_pc[i];
        // x0 writes still count as retires and consume a seq number.
        if (!(FILTER_X0 != 0 && wb_rd[i] == 5'd0)) begin
          if (n_enq < free) begin
            enq[i] = 1'b1;
            n_enq  = n_enq + (AW+1)'(1);
          end else begin
            n_drop = n_drop + 16'd1;
          end
        end
      end
    end
    rep_nxt = (hi_pc == last_pc) ? rep_cnt + RW'(1) : RW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      seq        <= '0;
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      idle_cnt   <= '0;
      last_pc    <= '0;
      rep_cnt    <= '0;
    end else begin
      case (state)
        ST_RUN: if (enable) begin
          seq        <= seq + n_ret;
          retire_cnt <= retire_cnt + 32'(n_ret);
          drop_cnt   <= sat_add16(drop_cnt, n_drop);
          if (n_drop != '0) overflow <= 1'b1;
          if (any_ret) begin
            idle_cnt <= '0;
            last_pc  <= hi_pc;
            rep_cnt  <= rep_nxt;
            if (rep_nxt == RW'(HALT_REPEAT)) state <= ST_HALT;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
            if (idle_cnt == 32'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
          end
        end
        // Only reset leaves HALT; the watchdog is held here.
        ST_HALT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  assign halted = (state == ST_HALT);

  trace_fifo #(.NCH(NCH), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (enq),
    .push_entry (ent),
    .pop        (trc_valid && trc_ready),
    .head_valid (trc_valid),
    .head       (trc_entry),
    .count      (fcount)
  );
endmodule
